// File: rtl/output_drain_if.sv
// Stream bundle between the execute stage, the output drain and the pin-side consumer.
// The master view belongs to output_drain; the slave view belongs to whatever drives and consumes it.
interface output_drain_if;
  logic       out_valid;
  logic [2:0] reg_out;
  logic       halt_ex;
  logic [2:0] drain_data;
  logic       drain_valid;
  logic       drain_ready;

  modport master (
    input  out_valid, reg_out, halt_ex, drain_ready,
    output drain_data, drain_valid
  );

  modport slave (
    output out_valid, reg_out, halt_ex, drain_ready,
    input  drain_data, drain_valid
  );
endinterface

// File: rtl/output_drain.sv
// Captures execute-stage output values into a small FIFO and presents them on a valid/ready
// port; raises a sticky done once the core has halted and every captured value has left.
module output_drain #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output_drain_if.master     stream,
  output logic               done,
  output logic               overflow,
  output logic [CNT_W-1:0]   delivered
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]       count_reg, count_next;
  logic [CNT_W-1:0]  delivered_reg;
  logic              overflow_reg;
  logic              empty, push_req, push_ok, pop;

  assign empty    = (count_reg == '0);
  assign push_req = stream.out_valid && (state_reg != ST_DONE);
  assign pop      = !empty && stream.drain_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req && ((count_reg != FULL_CNT) || pop);

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push_ok) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (stream.halt_ex) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A value still in flight keeps us draining for another cycle.
        if (empty && !push_req) state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      delivered_reg <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (pop && (delivered_reg != '1)) delivered_reg <= delivered_reg + 1'b1;
      if (push_req && !push_ok) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= stream.reg_out;
  end

  assign stream.drain_valid = !empty;
  assign stream.drain_data  = empty ? 3'b000 : mem[rd_ptr_reg];
  assign overflow           = overflow_reg;
  assign delivered          = delivered_reg;

endmodule

// File: tb/tb_output_drain.sv
// Directed bench for output_drain: scoreboard of expected drain values, checked at each handshake.
module tb_output_drain;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  output_drain_if bus ();
  logic       done, overflow;
  logic [7:0] delivered;

  output_drain #(.DEPTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stream    (bus),
    .done      (done),
    .overflow  (overflow),
    .delivered (delivered)
  );

  output_drain_if bus3 ();
  logic       done3, overflow3;
  logic [2:0] delivered3;

  output_drain #(.DEPTH(2), .CNT_W(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .stream    (bus3),
    .done      (done3),
    .overflow  (overflow3),
    .delivered (delivered3)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         pops3    = 0;
  logic [2:0] sb  [$];
  logic [2:0] sb3 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; handshakes are judged on the falling edge before the edge that completes them.
  task automatic tick();
    logic [2:0] exp;
    @(negedge clk);
    if (bus.drain_valid && bus.drain_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", sb.size(), 1);
      end else begin
        exp = sb.pop_front();
        $display("pop  data=%0d expected=%0d", bus.drain_data, exp);
        chk("drain_data", bus.drain_data, exp);
      end
    end
    if (bus3.drain_valid && bus3.drain_ready) begin
      if (sb3.size() == 0) begin
        chk("unexpected_pop3", sb3.size(), 1);
      end else begin
        exp = sb3.pop_front();
        pops3++;
        $display("pop3 data=%0d expected=%0d", bus3.drain_data, exp);
        chk("drain_data3", bus3.drain_data, exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_acc(input logic [2:0] v);
    bus.out_valid = 1'b1;
    bus.reg_out   = v;
    sb.push_back(v);
    $display("push data=%0d", v);
    tick();
    bus.out_valid = 1'b0;
  endtask

  task automatic push_drop(input logic [2:0] v);
    bus.out_valid = 1'b1;
    bus.reg_out   = v;
    $display("push data=%0d (expected drop)", v);
    tick();
    bus.out_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    sb.delete();
  endtask

  initial begin
    bus.out_valid = 1'b0;  bus.reg_out = 3'd0;  bus.halt_ex = 1'b0;  bus.drain_ready = 1'b0;
    bus3.out_valid = 1'b0; bus3.reg_out = 3'd0; bus3.halt_ex = 1'b0; bus3.drain_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_drain_valid", bus.drain_valid, 0);
    chk("rst_drain_data",  bus.drain_data, 0);
    chk("rst_done",        done, 0);
    chk("rst_overflow",    overflow, 0);
    chk("rst_delivered",   delivered, 0);
    rst_n = 1'b1;
    tick();

    // Basic ordering
    push_acc(3'd2); push_acc(3'd4); push_acc(3'd1); push_acc(3'd7);
    chk("basic_valid", bus.drain_valid, 1);
    chk("basic_head",  bus.drain_data, 2);
    bus.drain_ready = 1'b1;
    repeat (4) tick();
    bus.drain_ready = 1'b0;
    chk("basic_delivered", delivered, 4);
    chk("basic_empty",     bus.drain_valid, 0);
    chk("basic_sb_empty",  sb.size(), 0);

    // Full and overflow
    do_reset();
    for (int i = 0; i < 8; i++) push_acc(3'(i));
    chk("full_no_ovf", overflow, 0);
    push_drop(3'd5);
    chk("ovf_set", overflow, 1);
    bus.drain_ready = 1'b1;
    repeat (8) tick();
    bus.drain_ready = 1'b0;
    chk("ovf_drained_empty", bus.drain_valid, 0);
    chk("ovf_delivered",     delivered, 8);
    chk("ovf_sticky",        overflow, 1);
    chk("ovf_sb_empty",      sb.size(), 0);

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) push_acc(3'(7 - i));
    bus.drain_ready = 1'b1;
    bus.out_valid   = 1'b1;
    bus.reg_out     = 3'd6;
    sb.push_back(3'd6);
    tick();
    bus.out_valid = 1'b0;
    chk("fullpp_no_ovf", overflow, 0);
    repeat (8) tick();
    bus.drain_ready = 1'b0;
    chk("fullpp_empty",     bus.drain_valid, 0);
    chk("fullpp_delivered", delivered, 9);
    chk("fullpp_sb_empty",  sb.size(), 0);

    // Halt and drain
    do_reset();
    push_acc(3'd3);
    bus.halt_ex = 1'b1;
    push_acc(3'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_wait_done", done, 0);
    end
    bus.drain_ready = 1'b1;
    tick();
    chk("halt_pop1_done", done, 0);
    tick();
    chk("halt_pop2_done", done, 0);
    chk("halt_pop2_empty", bus.drain_valid, 0);
    tick();
    chk("halt_done", done, 1);
    bus.drain_ready = 1'b0;
    push_drop(3'd5);
    chk("halt_ignore_ovf",   overflow, 0);
    chk("halt_ignore_valid", bus.drain_valid, 0);
    chk("halt_done_sticky",  done, 1);
    chk("halt_delivered",    delivered, 2);

    // Empty halt: done exactly two edges later
    bus.halt_ex = 1'b0;
    do_reset();
    chk("ehalt_reset_done", done, 0);
    bus.halt_ex = 1'b1;
    tick();
    chk("ehalt_edge1", done, 0);
    tick();
    chk("ehalt_edge2", done, 1);
    bus.halt_ex = 1'b0;

    // Asynchronous reset mid-stream with 5 entries queued
    do_reset();
    for (int i = 0; i < 5; i++) push_acc(3'(i + 1));
    chk("mid_valid", bus.drain_valid, 1);
    bus.drain_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",     bus.drain_valid, 0);
    chk("mid_rst_data",      bus.drain_data, 0);
    chk("mid_rst_delivered", delivered, 0);
    chk("mid_rst_done",      done, 0);
    chk("mid_rst_overflow",  overflow, 0);
    sb.delete();
    bus.drain_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_post_valid",     bus.drain_valid, 0);
    chk("mid_post_delivered", delivered, 0);

    // Saturating counter on the CNT_W=3, DEPTH=2 instance, consumer always ready
    bus3.drain_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus3.out_valid = 1'b1;
      bus3.reg_out   = 3'(i);
      sb3.push_back(3'(i));
      tick();
      chk("sat_delivered", delivered3, (pops3 > 7) ? 7 : pops3);
    end
    bus3.out_valid = 1'b0;
    tick();
    chk("sat_pops",      pops3, 9);
    chk("sat_hold",      delivered3, 7);
    chk("sat_no_ovf",    overflow3, 0);
    chk("sat_empty",     bus3.drain_valid, 0);
    bus3.drain_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
